// File: rtl/tomasulo_pkg.sv
// rtl/tomasulo_pkg.sv - shared opcodes, tag constants and reservation-station entry type
package tomasulo_pkg;

  localparam int RS_DATA_W = 16;
  localparam int RS_TAG_W  = 3;

  localparam logic [3:0] OP_ADD = 4'b0000;
  localparam logic [3:0] OP_SUB = 4'b0001;
  localparam logic [3:0] OP_BNE = 4'b0010;
  localparam logic [3:0] OP_LD  = 4'b0011;
  localparam logic [3:0] OP_SD  = 4'b0100;

  localparam logic [RS_TAG_W-1:0] TAG_NONE = '0;

  // Entry fields are sized by the package widths; stations must use matching DATA_W/TAG_W.
  typedef struct packed {
    logic                 busy;
    logic [3:0]           op;
    logic [RS_DATA_W-1:0] vj;
    logic [RS_DATA_W-1:0] vk;
    logic [RS_TAG_W-1:0]  qj;
    logic [RS_TAG_W-1:0]  qk;
    logic [RS_TAG_W-1:0]  dest;
  } rs_entry_t;

  function automatic logic is_adder_op(input logic [3:0] op);
    return (op == OP_ADD) || (op == OP_SUB) || (op == OP_BNE);
  endfunction

endpackage

// File: rtl/rs_age_matrix.sv
// rtl/rs_age_matrix.sv - pairwise age tracking and oldest-ready one-hot selection
module rs_age_matrix
  import tomasulo_pkg::*;
#(
  parameter  int ENTRIES = 4,
  localparam int IDX_W   = $clog2(ENTRIES)
) (
  input  logic               Clock,
  input  logic               Reset,
  input  logic               clear,
  input  logic               alloc1_en,
  input  logic [IDX_W-1:0]   alloc1_idx,
  input  logic               alloc2_en,
  input  logic [IDX_W-1:0]   alloc2_idx,
  input  logic               free_en,
  input  logic [IDX_W-1:0]   free_idx,
  input  logic [ENTRIES-1:0] ready,
  output logic [ENTRIES-1:0] oldest_oh
);

  // age_q[i][j] = 1 means entry i is older than entry j
  logic [ENTRIES-1:0] age_q [ENTRIES];
  logic [ENTRIES-1:0] age_n [ENTRIES];

  // A new entry is younger than everything; alloc1 is applied first so it ends older than alloc2.
  always_comb begin
    for (int i = 0; i < ENTRIES; i++) begin
      for (int j = 0; j < ENTRIES; j++) begin
        age_n[i][j] = age_q[i][j];
        if (free_en && ((IDX_W'(i) == free_idx) || (IDX_W'(j) == free_idx)))
          age_n[i][j] = 1'b0;
        if (alloc1_en && (IDX_W'(i) == alloc1_idx))
          age_n[i][j] = 1'b0;
        if (alloc1_en && (IDX_W'(j) == alloc1_idx))
          age_n[i][j] = 1'b1;
        if (alloc2_en && (IDX_W'(i) == alloc2_idx))
          age_n[i][j] = 1'b0;
        if (alloc2_en && (IDX_W'(j) == alloc2_idx))
          age_n[i][j] = 1'b1;
        if (clear)
          age_n[i][j] = 1'b0;
      end
    end
  end

  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      for (int i = 0; i < ENTRIES; i++)
        age_q[i] <= '0;
    end else begin
      for (int i = 0; i < ENTRIES; i++)
        age_q[i] <= age_n[i];
    end
  end

  always_comb begin
    for (int i = 0; i < ENTRIES; i++) begin
      oldest_oh[i] = ready[i];
      for (int j = 0; j < ENTRIES; j++) begin
        if ((j != i) && ready[j] && age_q[j][i])
          oldest_oh[i] = 1'b0;
      end
    end
  end

endmodule

// File: rtl/adder_rs.sv
// rtl/adder_rs.sv - dual-dispatch adder reservation station with CDB wakeup and oldest-first issue
module adder_rs
  import tomasulo_pkg::*;
#(
  parameter  int ENTRIES = 4,
  parameter  int DATA_W  = RS_DATA_W,
  parameter  int TAG_W   = RS_TAG_W,
  localparam int IDX_W   = $clog2(ENTRIES),
  localparam int CNT_W   = $clog2(ENTRIES + 1)
) (
  input  logic              Clock,
  input  logic              Reset,
  input  logic              flush,
  input  logic              d1_valid,
  input  logic [3:0]        d1_op,
  input  logic [DATA_W-1:0] d1_vj,
  input  logic [DATA_W-1:0] d1_vk,
  input  logic [TAG_W-1:0]  d1_qj,
  input  logic [TAG_W-1:0]  d1_qk,
  input  logic [TAG_W-1:0]  d1_dest,
  input  logic              d2_valid,
  input  logic [3:0]        d2_op,
  input  logic [DATA_W-1:0] d2_vj,
  input  logic [DATA_W-1:0] d2_vk,
  input  logic [TAG_W-1:0]  d2_qj,
  input  logic [TAG_W-1:0]  d2_qk,
  input  logic [TAG_W-1:0]  d2_dest,
  output logic              d1_ready,
  output logic              d2_ready,
  input  logic              cdb_valid,
  input  logic [TAG_W-1:0]  cdb_tag,
  input  logic [DATA_W-1:0] cdb_data,
  output logic              iss_valid,
  output logic [3:0]        iss_op,
  output logic [DATA_W-1:0] iss_a,
  output logic [DATA_W-1:0] iss_b,
  output logic [TAG_W-1:0]  iss_dest,
  input  logic              fu_ready,
  output logic [CNT_W-1:0]  free_cnt
);

  rs_entry_t          ent_q [ENTRIES];
  rs_entry_t          ent_n [ENTRIES];
  rs_entry_t          new1;
  rs_entry_t          new2;
  logic [ENTRIES-1:0] busy;
  logic [ENTRIES-1:0] rdy;
  logic [ENTRIES-1:0] oldest_oh;
  logic               f1_found, f2_found;
  logic [IDX_W-1:0]   f1_idx, f2_idx;
  logic               alloc1, alloc2;
  logic [IDX_W-1:0]   a2_idx;
  logic [IDX_W-1:0]   iss_idx;
  logic               issue_fire;
  logic               cdb_hit;

  always_comb begin
    for (int i = 0; i < ENTRIES; i++) begin
      busy[i] = ent_q[i].busy;
      rdy[i]  = ent_q[i].busy && (ent_q[i].qj == TAG_NONE) && (ent_q[i].qk == TAG_NONE);
    end
  end

  always_comb begin
    free_cnt = CNT_W'(ENTRIES);
    for (int i = 0; i < ENTRIES; i++)
      free_cnt = free_cnt - CNT_W'(busy[i]);
  end

  // Ready flags look only at registered occupancy; a slot freed by this cycle's issue is not reused.
  assign d1_ready = (free_cnt != '0);
  assign d2_ready = (free_cnt > CNT_W'(1)) || ((free_cnt != '0) && !d1_valid);

  always_comb begin
    f1_found = 1'b0;
    f2_found = 1'b0;
    f1_idx   = '0;
    f2_idx   = '0;
    for (int i = 0; i < ENTRIES; i++) begin
      if (!busy[i]) begin
        if (!f1_found) begin
          f1_found = 1'b1;
          f1_idx   = IDX_W'(i);
        end else if (!f2_found) begin
          f2_found = 1'b1;
          f2_idx   = IDX_W'(i);
        end
      end
    end
  end

  assign alloc1 = d1_valid && d1_ready && is_adder_op(d1_op) && !flush;
  assign alloc2 = d2_valid && d2_ready && is_adder_op(d2_op) && !flush;
  assign a2_idx = alloc1 ? f2_idx : f1_idx;
  assign cdb_hit = cdb_valid && (cdb_tag != TAG_NONE);

  // Incoming operands can be captured straight off the CDB in the dispatch cycle.
  always_comb begin
    new1      = '0;
    new1.busy = 1'b1;
    new1.op   = d1_op;
    new1.vj   = d1_vj;
    new1.vk   = d1_vk;
    new1.qj   = d1_qj;
    new1.qk   = d1_qk;
    new1.dest = d1_dest;
    if (cdb_hit && (d1_qj == cdb_tag)) begin
      new1.vj = cdb_data;
      new1.qj = TAG_NONE;
    end
    if (cdb_hit && (d1_qk == cdb_tag)) begin
      new1.vk = cdb_data;
      new1.qk = TAG_NONE;
    end
    new2      = '0;
    new2.busy = 1'b1;
    new2.op   = d2_op;
    new2.vj   = d2_vj;
    new2.vk   = d2_vk;
    new2.qj   = d2_qj;
    new2.qk   = d2_qk;
    new2.dest = d2_dest;
    if (cdb_hit && (d2_qj == cdb_tag)) begin
      new2.vj = cdb_data;
      new2.qj = TAG_NONE;
    end
    if (cdb_hit && (d2_qk == cdb_tag)) begin
      new2.vk = cdb_data;
      new2.qk = TAG_NONE;
    end
  end

  always_comb begin
    iss_valid = |rdy;
    iss_op    = '0;
    iss_a     = '0;
    iss_b     = '0;
    iss_dest  = '0;
    iss_idx   = '0;
    for (int i = 0; i < ENTRIES; i++) begin
      if (oldest_oh[i]) begin
        iss_op   = ent_q[i].op;
        iss_a    = ent_q[i].vj;
        iss_b    = ent_q[i].vk;
        iss_dest = ent_q[i].dest;
        iss_idx  = IDX_W'(i);
      end
    end
  end

  assign issue_fire = iss_valid && fu_ready;

  always_comb begin
    for (int i = 0; i < ENTRIES; i++) begin
      ent_n[i] = ent_q[i];
      if (cdb_hit && ent_q[i].busy && (ent_q[i].qj == cdb_tag)) begin
        ent_n[i].vj = cdb_data;
        ent_n[i].qj = TAG_NONE;
      end
      if (cdb_hit && ent_q[i].busy && (ent_q[i].qk == cdb_tag)) begin
        ent_n[i].vk = cdb_data;
        ent_n[i].qk = TAG_NONE;
      end
      if (issue_fire && oldest_oh[i])
        ent_n[i].busy = 1'b0;
      if (alloc1 && (f1_idx == IDX_W'(i)))
        ent_n[i] = new1;
      if (alloc2 && (a2_idx == IDX_W'(i)))
        ent_n[i] = new2;
      if (flush)
        ent_n[i] = '0;
    end
  end

  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      for (int i = 0; i < ENTRIES; i++)
        ent_q[i] <= '0;
    end else begin
      for (int i = 0; i < ENTRIES; i++)
        ent_q[i] <= ent_n[i];
    end
  end

  rs_age_matrix #(
    .ENTRIES (ENTRIES)
  ) u_age (
    .Clock      (Clock),
    .Reset      (Reset),
    .clear      (flush),
    .alloc1_en  (alloc1),
    .alloc1_idx (f1_idx),
    .alloc2_en  (alloc2),
    .alloc2_idx (a2_idx),
    .free_en    (issue_fire),
    .free_idx   (iss_idx),
    .ready      (rdy),
    .oldest_oh  (oldest_oh)
  );

endmodule

// File: doc/adder_rs.md
Name: adder_rs

Overview:
- Adder reservation station at the receiving end of the dual-dispatch instruction queue.
- Accepts up to two ADD.D/SUB.D/BNE.D instructions per cycle on two dispatch ports, which correspond to Adderin and Adderin2.
- Holds each instruction until its operands arrive on the common data bus (CDB), then issues the oldest ready entry to the adder functional unit.
- Reports free capacity every cycle so the queue can stall instead of dropping instructions.

Parameters:
- ENTRIES, 4, number of station slots (2..8).
- DATA_W, 16, operand and CDB data width.
- TAG_W, 3, producer-tag width. Tag value 0 means "operand value present".

Ports:
- Clock  in  1  rising-edge clock.
- Reset  in  1  asynchronous, active-low reset.
- flush  in  1  synchronous clear of all entries (BNE.D mispredict).
- d1_valid  in  1  dispatch slot 1 valid (Adderin).
- d1_op  in  4  opcode: 0000 ADD.D, 0001 SUB.D, 0010 BNE.D.
- d1_vj, d1_vk  in  DATA_W each  operand values, meaningful when the matching Q is 0.
- d1_qj, d1_qk  in  TAG_W each  producer tags.
- d1_dest  in  TAG_W  result tag (nonzero).
- d2_valid, d2_op, d2_vj, d2_vk, d2_qj, d2_qk, d2_dest  in  same widths as slot 1  dispatch slot 2 (Adderin2).
- d1_ready  out  1  slot 1 will be accepted this cycle.
- d2_ready  out  1  slot 2 will be accepted this cycle.
- cdb_valid  in  1  CDB broadcast valid.
- cdb_tag  in  TAG_W  CDB tag.
- cdb_data  in  DATA_W  CDB value.
- iss_valid  out  1  an entry is ready to issue.
- iss_op  out  4  opcode of the issuing entry.
- iss_a, iss_b  out  DATA_W each  operands of the issuing entry.
- iss_dest  out  TAG_W  result tag of the issuing entry.
- fu_ready  in  1  adder accepts an issue this cycle.
- free_cnt  out  clog2(ENTRIES+1)  number of free slots.

Behaviour:
- Reset (Reset=0, async): all entries invalid; age matrix cleared; free_cnt=ENTRIES; iss_valid=0; iss_op/a/b/dest=0; d1_ready=1; d2_ready=(ENTRIES>=2).
- Entry state: busy, op, vj, vk, qj, qk, dest. An entry is ready when busy and qj==0 and qk==0.
- d1_ready = free_cnt>=1.
- d2_ready = free_cnt>=2, or (free_cnt>=1 and !d1_valid).
- Both ready signals are computed from registered state only. A slot freed by an issue in the same cycle is not counted.
- Acceptance: slot n is accepted when dn_valid && dn_ready.
- Slot placement: slot 1 takes the lowest free index; slot 2 takes the next lowest free index. When both are accepted, slot 1 is older than slot 2 in the age matrix.
- Opcodes other than 0000/0001/0010 on an accepted slot are ignored: no entry is allocated and no error is raised.
- Dispatch/CDB bypass: if cdb_valid and cdb_tag equals an incoming nonzero qj/qk in the same cycle, the entry is written with Q=0 and V=cdb_data.
- CDB wakeup: every busy entry with qj==cdb_tag (nonzero) sets vj=cdb_data and qj=0 at the edge. The same rule applies independently to qk. A single broadcast may wake both operands of an entry.
- Issue:
  - iss_valid = any entry ready.
  - The selected entry is the oldest ready entry per the age matrix.
  - Issue outputs are combinational from registered state. When iss_valid=0 they hold 0.
  - Handshake: on iss_valid && fu_ready the selected entry is freed at the edge.
  - If fu_ready=0, the outputs stay stable unless an older entry becomes ready.
- Latency: an instruction dispatched, or woken by the CDB, at edge N can issue at the earliest in cycle N+1. Zero-cycle dispatch-to-issue does not exist.
- Throughput: one issue per cycle.
- Simultaneous dispatch of two slots, one issue and one CDB wakeup in a single cycle is legal and all take effect.
- Full: with free_cnt=0, d1_ready=d2_ready=0 and the dispatch inputs are ignored.
- flush: at the edge all entries become invalid, dispatches in that cycle are dropped, and any issue handshake in that cycle is still reported to the FU. flush takes priority over dispatch.
- Reset asserted mid-operation discards everything immediately (asynchronous).
- free_cnt always equals ENTRIES minus the popcount of busy; it is updated at each edge.

Decomposition:
- Shared package tomasulo_pkg:
  - opcode constants OP_ADD=4'b0000, OP_SUB=4'b0001, OP_BNE=4'b0010, OP_LD=4'b0011, OP_SD=4'b0100;
  - TAG_NONE=0;
  - rs_entry_t struct (busy, op, vj, vk, qj, qk, dest).
- One natural sub-module, rs_age_matrix: an ENTRIES×ENTRIES age bit matrix with inputs alloc1/alloc2 index, free index, ready vector, clear, and output oldest-ready one-hot.

Test Plan:
- Reset, then dispatch d1 ADD (vj=5, vk=7, qj=qk=0, dest=1) with fu_ready=1 → next cycle iss_valid=1, iss_op=0000, iss_a=5, iss_b=7, iss_dest=1; one cycle later free_cnt=4.
- Dispatch SUB with qj=3, vk=2; hold 3 cycles, then CDB tag=3 data=9 → iss_valid stays 0 until the cycle after the broadcast, then iss_a=9, iss_b=2.
- Same-cycle bypass: dispatch ADD with qk=4 while cdb_valid=1, tag=4, data=0x00AA → next cycle issue with iss_b=0x00AA.
- Fill with 4 entries all waiting on tag 5 (fu_ready=0) → free_cnt=0, d1_ready=d2_ready=0; a further d1 dispatch is ignored. Then CDB tag 5 with fu_ready=1 → issues in dispatch order over 4 cycles.
- Dual dispatch in one cycle (slot1 dest=2, slot2 dest=3, both ready) with fu_ready=1 → dest 2 issues before dest 3.
- With 3 entries busy, assert flush and d1_valid together → free_cnt=4 after the edge and iss_valid=0. Separately, pulse Reset low mid-wait → all outputs return to their reset values without waiting for a clock edge.
